// File: rtl/block_byte_merger_if.sv
// rtl/block_byte_merger_if.sv - handshake bundle for block_byte_merger
//   load_*  : line capture request from producer (load_ready back)
//   wr_*    : byte write into held line (wr_ready back)
//   flush   : request to emit the merged line
//   out_*   : merged line, per-byte written mask, consumer out_ready
//   dirty   : OR of out_mask
interface block_byte_merger_if;
    logic         load_valid;
    logic [511:0] load_block;
    logic         load_ready;
    logic         wr_valid;
    logic [5:0]   wr_offset;
    logic [7:0]   wr_byte;
    logic         wr_ready;
    logic         flush;
    logic         out_valid;
    logic [511:0] out_block;
    logic [63:0]  out_mask;
    logic         out_ready;
    logic         dirty;

    modport master (
        output load_valid, load_block, wr_valid, wr_offset, wr_byte, flush, out_ready,
        input  load_ready, wr_ready, out_valid, out_block, out_mask, dirty
    );

    modport slave (
        input  load_valid, load_block, wr_valid, wr_offset, wr_byte, flush, out_ready,
        output load_ready, wr_ready, out_valid, out_block, out_mask, dirty
    );
endinterface

// File: rtl/block_byte_merger.sv
// rtl/block_byte_merger.sv - 64-byte line buffer with byte-granular merge and drain
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : block_byte_merger_if.slave (load, byte write, flush, drain handshakes)
module block_byte_merger (
    input  logic                      clk,
    input  logic                      reset_n,
    block_byte_merger_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t       state;
    logic [511:0] line_q;
    logic [63:0]  mask_q;
    logic         load_ready_q;
    logic         wr_ready_q;
    logic         out_valid_q;

    // Byte k sits at bits [8k+7:8k]; offset[5:3] picks the 64-bit word and
    // offset[2:0] the byte inside it, so the low bit index is simply offset*8.
    logic [8:0]   wr_lsb;
    assign wr_lsb = {bus.wr_offset, 3'b000};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            line_q       <= '0;
            mask_q       <= '0;
            load_ready_q <= 1'b1;
            wr_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        line_q       <= bus.load_block;
                        mask_q       <= '0;
                        state        <= HOLD;
                        load_ready_q <= 1'b0;
                        wr_ready_q   <= 1'b1;
                    end
                end
                HOLD: begin
                    // A write coinciding with flush still lands, so the byte is
                    // already in the line when out_valid first rises.
                    if (bus.wr_valid) begin
                        line_q[wr_lsb +: 8]   <= bus.wr_byte;
                        mask_q[bus.wr_offset] <= 1'b1;
                    end
                    if (bus.flush) begin
                        state       <= DRAIN;
                        wr_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Line contents are kept after the transfer; only the mask
                    // is cleared so dirty drops with out_valid.
                    if (bus.out_ready) begin
                        state        <= IDLE;
                        mask_q       <= '0;
                        out_valid_q  <= 1'b0;
                        load_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    mask_q       <= '0;
                    load_ready_q <= 1'b1;
                    wr_ready_q   <= 1'b0;
                    out_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.wr_ready   = wr_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_block  = line_q;
    assign bus.out_mask   = mask_q;
    assign bus.dirty      = |mask_q;

endmodule

// File: tb/tb_block_byte_merger.sv
// tb/tb_block_byte_merger.sv - scoreboard bench for block_byte_merger
module tb_block_byte_merger;

    logic clk;
    logic reset_n;

    block_byte_merger_if bus();

    block_byte_merger dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] blk;
        logic [63:0]  mask;
        logic         dirty;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a line, it must match the head of
    // the expected queue; the entry retires only on the accepting handshake,
    // so stalled cycles also prove the output holds steady.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got out_valid=1 expected no pending line");
            end else begin
                chk("out_block", bus.out_block, exp_q[0].blk);
                chk("out_mask", {448'd0, bus.out_mask}, {448'd0, exp_q[0].mask});
                chk("dirty", {511'd0, bus.dirty}, {511'd0, exp_q[0].dirty});
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [511:0] b, input logic [63:0] m, input logic d);
        exp_t e;
        e.blk   = b;
        e.mask  = m;
        e.dirty = d;
        exp_q.push_back(e);
    endtask

    task automatic do_load(input logic [511:0] b);
        bus.load_valid = 1'b1;
        bus.load_block = b;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] off, input logic [7:0] b, input logic fl);
        bus.wr_valid  = 1'b1;
        bus.wr_offset = off;
        bus.wr_byte   = b;
        bus.flush     = fl;
        tick();
        bus.wr_valid  = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_flush;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic do_drain;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_ctl(input string name, input logic lr, input logic wr, input logic ov);
        chk({name, "_load_ready"}, {511'd0, bus.load_ready}, {511'd0, lr});
        chk({name, "_wr_ready"}, {511'd0, bus.wr_ready}, {511'd0, wr});
        chk({name, "_out_valid"}, {511'd0, bus.out_valid}, {511'd0, ov});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] ones;
        logic [511:0] pat;
        logic [511:0] e;

        ones = '1;
        reset_n        = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_block = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_offset  = '0;
        bus.wr_byte    = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_ctl("reset", 1'b1, 1'b0, 1'b0);
        chk("reset_dirty", {511'd0, bus.dirty}, 512'd0);
        chk("reset_mask", {448'd0, bus.out_mask}, 512'd0);
        chk("reset_block", bus.out_block, 512'd0);

        // Load all-FF on the first edge after release, single write at offset 0
        tick();
        reset_n = 1'b1;
        do_load(ones);
        chk_ctl("hold", 1'b0, 1'b1, 1'b0);
        do_write(6'd0, 8'h0F, 1'b0);
        e = ones;
        e[7:0] = 8'h0F;
        push_exp(e, 64'h1, 1'b1);
        do_flush();
        chk_ctl("drain", 1'b0, 1'b0, 1'b1);
        do_drain();
        chk_ctl("idle_after_drain", 1'b1, 1'b0, 1'b0);

        // Word and byte boundaries, one byte per cycle
        do_load('0);
        do_write(6'd7, 8'hAB, 1'b0);
        do_write(6'd8, 8'h56, 1'b0);
        do_write(6'd63, 8'hC3, 1'b0);
        e = '0;
        e[63:56]   = 8'hAB;
        e[71:64]   = 8'h56;
        e[511:504] = 8'hC3;
        push_exp(e, 64'h8000_0000_0000_0180, 1'b1);
        do_flush();
        do_drain();

        // Write and flush together
        do_load('0);
        e = '0;
        e[15:8] = 8'h22;
        push_exp(e, 64'h2, 1'b1);
        do_write(6'd1, 8'h22, 1'b1);
        chk_ctl("wr_flush", 1'b0, 1'b0, 1'b1);
        do_drain();

        // Stray wr_valid/flush in IDLE are ignored
        bus.wr_valid  = 1'b1;
        bus.wr_offset = 6'd4;
        bus.wr_byte   = 8'hEE;
        bus.flush     = 1'b1;
        tick();
        bus.wr_valid  = 1'b0;
        bus.flush     = 1'b0;
        chk_ctl("idle_ignore", 1'b1, 1'b0, 1'b0);
        chk("idle_ignore_mask", {448'd0, bus.out_mask}, 512'd0);

        // Back-pressure with stray write/load in DRAIN
        pat = {16{32'hDEADBEEF}};
        do_load(pat);
        do_write(6'd10, 8'h5A, 1'b0);
        e = pat;
        e[87:80] = 8'h5A;
        push_exp(e, 64'h400, 1'b1);
        do_flush();
        bus.wr_valid   = 1'b1;
        bus.wr_offset  = 6'd10;
        bus.wr_byte    = 8'hFF;
        bus.load_valid = 1'b1;
        bus.load_block = '0;
        repeat (5) tick();
        chk_ctl("stall", 1'b0, 1'b0, 1'b1);
        bus.wr_valid   = 1'b0;
        bus.load_valid = 1'b0;
        do_drain();
        chk_ctl("after_stall", 1'b1, 1'b0, 1'b0);
        chk("after_stall_mask", {448'd0, bus.out_mask}, 512'd0);
        chk("after_stall_dirty", {511'd0, bus.dirty}, 512'd0);
        chk("after_stall_retained", bus.out_block, e);

        // Overwrite of the same offset
        pat = {64{8'hA5}};
        do_load(pat);
        do_write(6'd5, 8'h11, 1'b0);
        do_write(6'd5, 8'h99, 1'b0);
        e = pat;
        e[47:40] = 8'h99;
        push_exp(e, 64'h20, 1'b1);
        do_flush();
        do_drain();

        // Empty flush still drains, dirty low
        do_load(ones);
        push_exp(ones, 64'h0, 1'b0);
        do_flush();
        chk_ctl("empty_flush", 1'b0, 1'b0, 1'b1);
        chk("empty_flush_dirty", {511'd0, bus.dirty}, 512'd0);
        do_drain();

        // Reset mid-HOLD, between edges
        do_load(ones);
        do_write(6'd3, 8'h77, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_ctl("async_reset", 1'b1, 1'b0, 1'b0);
        chk("async_reset_mask", {448'd0, bus.out_mask}, 512'd0);
        chk("async_reset_dirty", {511'd0, bus.dirty}, 512'd0);
        chk("async_reset_block", bus.out_block, 512'd0);
        tick();
        reset_n = 1'b1;
        pat = {8{64'h0123_4567_89AB_CDEF}};
        do_load(pat);
        chk_ctl("reload", 1'b0, 1'b1, 1'b0);
        chk("reload_block", bus.out_block, pat);
        push_exp(pat, 64'h0, 1'b0);
        do_flush();
        do_drain();

        tick();
        chk("scoreboard_empty", 512'(exp_q.size()), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
